// File: rtl/sega_xor_decrypter.sv
// sega_xor_decrypter: table-driven XOR opcode/data decrypter with a load-checked
// mask table and CPU wait-state generation.
module sega_xor_decrypter #(
    parameter int                ADDR_W     = 16,
    parameter int                SEL_BITS   = 4,
    parameter int                SEL_STRIDE = 4,
    parameter logic [ADDR_W-1:0] DEC_TOP    = 16'h8000,
    parameter int                WAIT_CYC   = 1
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic [ADDR_W-1:0]     i_ADDR,
    input  logic                  i_MREQ_n,
    input  logic                  i_M1_n,
    input  logic [7:0]            i_DI,
    output logic [7:0]            o_DI_DEC,
    output logic                  o_WAIT_n,
    input  logic                  i_BYPASS,
    input  logic                  i_TBL_WR,
    input  logic [SEL_BITS+2:0]   i_TBL_ADDR,
    input  logic [7:0]            i_TBL_DATA,
    input  logic                  i_TBL_CLR,
    output logic                  o_TBL_VALID,
    output logic                  o_TBL_ERR
);
    localparam int IW    = SEL_BITS + 3;
    localparam int DEPTH = 2 ** IW;

    typedef enum logic [1:0] {BLANK, LOADING, ACTIVE} state_t;

    state_t                state, state_nx;
    logic [IW-1:0]         cnt;
    logic [7:0]            tbl [DEPTH];
    logic [7:0]            m;
    logic                  prev_mreq;
    logic [1:0]            wcnt;
    logic                  hold_r;
    logic [SEL_BITS-1:0]   row;
    logic [IW-1:0]         idx;
    logic                  in_win, active, accept, wr_bad, fetch_start, hold_any, dec_en;

    for (genvar k = 0; k < SEL_BITS; k++) begin : g_row
        assign row[k] = i_ADDR[SEL_STRIDE*k];
    end

    assign in_win      = i_ADDR < DEC_TOP;
    assign active      = state == ACTIVE;
    assign accept      = i_TBL_WR && !i_TBL_CLR && !active && i_TBL_ADDR == cnt;
    assign wr_bad      = i_TBL_WR && !i_TBL_CLR && !accept;
    assign idx         = {row, i_M1_n, i_DI[5] ^ i_DI[7], i_DI[3] ^ i_DI[7]};
    assign fetch_start = prev_mreq && !i_MREQ_n && !i_M1_n && in_win;
    // Until the table is usable, any in-window access stalls the CPU; the hold
    // persists through the first ACTIVE cycle so the mask register is primed.
    assign hold_any    = !i_BYPASS && (hold_r || (!active && !i_MREQ_n && in_win));

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) state <= BLANK;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = i_TBL_CLR                          ? BLANK   :
                   (accept && cnt == IW'(DEPTH - 1))  ? ACTIVE  :
                   accept                             ? LOADING : state;
    end

    always_comb begin
        o_TBL_VALID = active;
        dec_en      = active && !i_BYPASS && !i_MREQ_n && in_win;
        o_DI_DEC    = dec_en ? {m[7] ^ i_DI[7], i_DI[6], m[5] ^ i_DI[7], i_DI[4],
                                m[3] ^ i_DI[7], i_DI[2:0]} : i_DI;
        o_WAIT_n    = !(hold_any || wcnt != 2'd0);
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cnt       <= '0;
            m         <= 8'h00;
            prev_mreq <= 1'b1;
            wcnt      <= 2'd0;
            hold_r    <= 1'b0;
            o_TBL_ERR <= 1'b0;
        end else begin
            cnt       <= i_TBL_CLR ? '0 : accept ? cnt + IW'(1) : cnt;
            m         <= tbl[idx];
            prev_mreq <= i_MREQ_n;
            wcnt      <= i_TBL_CLR                              ? 2'd0           :
                         (active && !i_BYPASS && fetch_start)   ? 2'(WAIT_CYC)   :
                         wcnt != 2'd0                           ? wcnt - 2'd1    : wcnt;
            hold_r    <= hold_any && !active;
            o_TBL_ERR <= i_TBL_CLR ? 1'b0 : o_TBL_ERR | wr_bad;
        end
    end

    // Table RAM is deliberately not reset; its contents are meaningless until reloaded.
    always_ff @(posedge i_CLK) begin
        if (accept) tbl[cnt] <= i_TBL_DATA;
    end
endmodule

// File: tb/tb_sega_xor_decrypter.sv
// tb_sega_xor_decrypter: vector tables, directed corner sequences and a random
// decrypt check against a table-based reference model.
module tb_sega_xor_decrypter;
    logic        i_CLK = 1'b0, i_RST = 1'b1;
    logic [15:0] i_ADDR = 16'h0000;
    logic        i_MREQ_n = 1'b1, i_M1_n = 1'b1, i_BYPASS = 1'b0;
    logic [7:0]  i_DI = 8'h00, i_TBL_DATA = 8'h00;
    logic        i_TBL_WR = 1'b0, i_TBL_CLR = 1'b0;
    logic [6:0]  i_TBL_ADDR = 7'd0;
    logic [7:0]  o_DI_DEC;
    logic        o_WAIT_n, o_TBL_VALID, o_TBL_ERR;

    int          passed = 0, total = 0;
    logic [7:0]  mtbl [128];

    typedef struct { int idx; logic exp_err; logic exp_valid; } wvec_t;
    typedef struct { logic [15:0] a; logic m1n; logic [7:0] d; logic [7:0] exp; } dvec_t;

    always #5 i_CLK = ~i_CLK;

    sega_xor_decrypter #(.WAIT_CYC(2)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_ADDR(i_ADDR), .i_MREQ_n(i_MREQ_n),
        .i_M1_n(i_M1_n), .i_DI(i_DI), .o_DI_DEC(o_DI_DEC), .o_WAIT_n(o_WAIT_n),
        .i_BYPASS(i_BYPASS), .i_TBL_WR(i_TBL_WR), .i_TBL_ADDR(i_TBL_ADDR),
        .i_TBL_DATA(i_TBL_DATA), .i_TBL_CLR(i_TBL_CLR), .o_TBL_VALID(o_TBL_VALID),
        .o_TBL_ERR(o_TBL_ERR)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge i_CLK);
        #1;
    endtask

    task automatic load(input int lo, input int hi);
        for (int k = lo; k < hi; k++) begin
            i_TBL_WR   = 1'b1;
            i_TBL_ADDR = 7'(k);
            i_TBL_DATA = mtbl[k];
            tick;
        end
        i_TBL_WR = 1'b0;
    endtask

    // Expected CPU data in ACTIVE state, straight from the row/index/mask rules.
    function automatic logic [7:0] model_dec(input logic [15:0] a, input logic m1n,
                                             input logic [7:0] d, input logic byp,
                                             input logic mrq);
        int row = 0;
        int idx;
        logic [7:0] x;
        for (int k = 0; k < 4; k++) row += int'(a[4*k]) * (1 << k);
        idx = row * 8 + int'(m1n) * 4 + int'(d[5] ^ d[7]) * 2 + int'(d[3] ^ d[7]);
        x = d[7] ? 8'hA8 : 8'h00;
        if (byp || mrq || a >= 16'h8000) return d;
        return (d & 8'h57) | ((mtbl[idx] ^ x) & 8'hA8);
    endfunction

    initial begin
        wvec_t wv [3];
        dvec_t dv [3];
        wv[0] = '{0, 1'b0, 1'b0};
        wv[1] = '{1, 1'b0, 1'b0};
        wv[2] = '{5, 1'b1, 1'b0};
        dv[0] = '{16'h0000, 1'b0, 8'h00, 8'h20};
        dv[1] = '{16'h0000, 1'b0, 8'h80, 8'h28};
        dv[2] = '{16'h8000, 1'b0, 8'h80, 8'h80};
        for (int k = 0; k < 128; k++) mtbl[k] = 8'($urandom);
        mtbl[0] = 8'h20;
        mtbl[3] = 8'h80;

        i_DI = 8'h5A;
        #12;
        chk("rst_wait_n", o_WAIT_n, 1);
        chk("rst_valid", o_TBL_VALID, 0);
        chk("rst_err", o_TBL_ERR, 0);
        chk("rst_passthru", o_DI_DEC, 8'h5A);
        @(negedge i_CLK) i_RST = 1'b0;
        tick;

        for (int i = 0; i < 3; i++) begin
            i_TBL_WR   = 1'b1;
            i_TBL_ADDR = 7'(wv[i].idx);
            tick;
            i_TBL_WR = 1'b0;
            chk($sformatf("wr%0d_err", wv[i].idx), o_TBL_ERR, wv[i].exp_err);
            chk($sformatf("wr%0d_valid", wv[i].idx), o_TBL_VALID, wv[i].exp_valid);
        end
        load(2, 128);
        chk("cnt2_valid", o_TBL_VALID, 1);
        chk("cnt2_err_sticky", o_TBL_ERR, 1);

        i_TBL_CLR = 1'b1; i_TBL_WR = 1'b1; i_TBL_ADDR = 7'd0;
        tick;
        i_TBL_CLR = 1'b0; i_TBL_WR = 1'b0;
        chk("clr_err", o_TBL_ERR, 0);
        chk("clr_valid", o_TBL_VALID, 0);
        i_TBL_WR = 1'b1; i_TBL_ADDR = 7'd1;
        tick;
        i_TBL_WR = 1'b0;
        chk("clr_cnt0_err", o_TBL_ERR, 1);
        i_TBL_CLR = 1'b1;
        tick;
        i_TBL_CLR = 1'b0;
        chk("clr2_err", o_TBL_ERR, 0);

        load(0, 60);
        i_TBL_WR = 1'b1; i_TBL_ADDR = 7'd60; i_DI = 8'hA5;
        i_RST = 1'b1;
        #1;
        chk("midrst_valid", o_TBL_VALID, 0);
        chk("midrst_err", o_TBL_ERR, 0);
        chk("midrst_wait_n", o_WAIT_n, 1);
        chk("midrst_passthru", o_DI_DEC, 8'hA5);
        i_TBL_WR = 1'b0;
        #2 i_RST = 1'b0;
        tick;

        i_MREQ_n = 1'b0; i_ADDR = 16'h0100; i_DI = 8'hC3;
        #1;
        chk("blank_wait", o_WAIT_n, 0);
        i_BYPASS = 1'b1;
        #1;
        chk("bypass_release", o_WAIT_n, 1);
        chk("bypass_passthru", o_DI_DEC, 8'hC3);
        i_BYPASS = 1'b0;
        tick;
        chk("blank_hold", o_WAIT_n, 0);
        load(0, 64);
        chk("load_mid_wait", o_WAIT_n, 0);
        chk("load_mid_valid", o_TBL_VALID, 0);
        load(64, 127);
        i_TBL_WR = 1'b1; i_TBL_ADDR = 7'd127; i_TBL_DATA = mtbl[127];
        tick;
        i_TBL_WR = 1'b0;
        chk("reload_valid", o_TBL_VALID, 1);
        chk("reload_err", o_TBL_ERR, 0);
        chk("valid_cycle_wait", o_WAIT_n, 0);
        tick;
        chk("post_valid_release", o_WAIT_n, 1);

        i_MREQ_n = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            i_MREQ_n = 1'b0; i_M1_n = dv[i].m1n; i_ADDR = dv[i].a; i_DI = dv[i].d;
            tick;
            chk($sformatf("dec_vec%0d", i), o_DI_DEC, dv[i].exp);
            chk($sformatf("dec_vec%0d_valid", i), o_TBL_VALID, 1);
        end

        for (int i = 0; i < 300; i++) begin
            i_ADDR   = 16'($urandom);
            i_M1_n   = 1'($urandom);
            i_DI     = 8'($urandom);
            i_BYPASS = $urandom_range(0, 7) == 0;
            i_MREQ_n = $urandom_range(0, 3) == 0;
            tick;
            chk($sformatf("rand%0d_a%04h_d%02h", i, i_ADDR, i_DI), o_DI_DEC,
                model_dec(i_ADDR, i_M1_n, i_DI, i_BYPASS, i_MREQ_n));
        end

        i_BYPASS = 1'b0; i_MREQ_n = 1'b1; i_M1_n = 1'b1;
        tick; tick; tick;
        chk("idle_wait_n", o_WAIT_n, 1);
        i_MREQ_n = 1'b0; i_M1_n = 1'b0; i_ADDR = 16'h1234;
        #1;
        chk("fetch_pre_edge", o_WAIT_n, 1);
        tick; chk("fetch_w1", o_WAIT_n, 0);
        tick; chk("fetch_w2", o_WAIT_n, 0);
        tick; chk("fetch_done", o_WAIT_n, 1);

        i_MREQ_n = 1'b1; tick;
        i_MREQ_n = 1'b0; tick; chk("reload_a", o_WAIT_n, 0);
        i_MREQ_n = 1'b1; tick; chk("reload_b", o_WAIT_n, 0);
        i_MREQ_n = 1'b0; tick; chk("reload_c", o_WAIT_n, 0);
        tick; chk("reload_d", o_WAIT_n, 0);
        tick; chk("reload_done", o_WAIT_n, 1);

        i_MREQ_n = 1'b1; tick;
        i_ADDR = 16'h9000; i_MREQ_n = 1'b0;
        tick; chk("outwin_w1", o_WAIT_n, 1);
        tick; chk("outwin_w2", o_WAIT_n, 1);
        i_ADDR = 16'h7FFF; i_MREQ_n = 1'b1; tick;
        i_MREQ_n = 1'b0;
        tick; chk("edge_7fff_wait", o_WAIT_n, 0);

        i_MREQ_n = 1'b1; i_TBL_CLR = 1'b1;
        tick;
        i_TBL_CLR = 1'b0;
        chk("clr_abort_wait", o_WAIT_n, 1);
        chk("clr_abort_valid", o_TBL_VALID, 0);
        i_ADDR = 16'h0100; i_MREQ_n = 1'b0;
        #1;
        chk("clr_blank_hold", o_WAIT_n, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
